bcd_serial: RTL and testbench
=============================

// Module: bcd_serial
//
// PURPOSE
//   Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Generalises the fixed 8-bit combinational converter to any input width and
//   digit count, trading latency for area. Sits between the CPU/timer logic and
//   the score/debug display path; valid/ready handshake on input and output.
//
// PARAMETERS
//   WIDTH   8  binary input width in bits (>= 1)
//   DIGITS  3  BCD output digits; ceil(WIDTH*log10(2)) avoids overflow
//
// PORTS
//   clk        in   1           system clock, rising edge
//   reset      in   1           asynchronous, active-high
//   in_valid   in   1           in_data is valid
//   in_ready   out  1           converter can accept (high only in IDLE)
//   in_data    in   WIDTH       unsigned binary value
//   out_valid  out  1           out_bcd/out_overflow valid (high only in DONE)
//   out_ready  in   1           consumer takes result
//   out_bcd    out  4*DIGITS    packed BCD, digit 0 in bits [3:0]
//   out_ovf    out  1           value did not fit in DIGITS digits
//
// BEHAVIOUR
//   - One clock domain. Reset is asynchronous and active-high; clock port is clk, reset port is reset.
//   - Reset: state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_ovf=0, counter=0.
//   - FSM IDLE -> BUSY -> DONE -> IDLE.
//     IDLE: in_ready=1. in_valid&in_ready at edge E0: latch in_data into shift
//       register, clear BCD digits and ovf, bit counter=WIDTH, go BUSY.
//     BUSY: each edge: every digit >=5 gets +3 (all digits in parallel, from
//       current values), then {bcd,shift} shifts left 1, binary MSB enters digit
//       0 LSB; bit leaving digit DIGITS-1 ORs into ovf. Counter decrements;
//       at edge E_WIDTH (counter 1->0) go DONE.
//     DONE: out_valid=1; out_bcd/out_ovf stable until out_valid&out_ready,
//       then IDLE on that edge. out_ready ignored outside DONE.
//   - Latency: out_valid rises after edge E_WIDTH, i.e. WIDTH+1 cycles after the
//     acceptance cycle. Throughput: one conversion per WIDTH+2 cycles max.
//   - in_valid while not in_ready: ignored, no state change; in_data not sampled.
//   - Digit arithmetic 4-bit; after +3 a digit is <=12, fits before shift.
//   - out_bcd remains last result in IDLE (cleared only on next acceptance or reset).
//   - On overflow out_bcd holds the low DIGITS digits (value mod 10^DIGITS).
//   - Reset mid-BUSY or mid-DONE: conversion discarded, reset values at once.
//   - WIDTH=1: one BUSY cycle; DIGITS=1 valid.
//
// CONFIGURATION
//   BCD_SERIAL_BLANK_EN
//   - Defined: in DONE, leading zero digits above digit 0 output as 4'hF
//     (blank code for display decoder); digit 0 never blanked; ovf unaffected.
//     Blanking applied combinationally to out_bcd; internal digits unchanged.
//   - Undefined: out_bcd is plain BCD with leading zeros; no blanking logic.
//
// TESTING
//   1. WIDTH=8,DIGITS=3: send 255 -> out_valid exactly 9 cycles after accept,
//      out_bcd=12'h255, out_ovf=0; in_ready low throughout BUSY/DONE.
//   2. Sweep 0..255 back-to-back, out_ready=1 -> each out_bcd matches decimal
//      of input (0 -> 12'h000, 100 -> 12'h100, 199 -> 12'h199).
//   3. Backpressure: 42 with out_ready=0 for 20 cycles -> out_valid, out_bcd=
//      12'h042 held stable; new in_valid ignored; out_ready=1 -> IDLE next cycle.
//   4. Reset asserted mid-BUSY (cycle 4 of 8) -> outputs zero, in_ready=1
//      immediately; next conversion of 7 returns 12'h007.
//   5. WIDTH=16,DIGITS=5: 65535 -> 20'h65535 after 17 cycles; WIDTH=8,DIGITS=2:
//      255 -> out_bcd=8'h55, out_ovf=1.
//   6. BCD_SERIAL_BLANK_EN, WIDTH=8: 7 -> 12'hFF7; 0 -> 12'hFF0; 105 -> 12'h105.

Source files
------------

// File: rtl/bcd_serial.sv
// bcd_serial -- multi-cycle binary-to-BCD converter (shift-and-add-3).
//
// Converts an unsigned WIDTH-bit value into DIGITS packed BCD digits. The
// converter processes one input bit per clock, so a conversion takes WIDTH
// BUSY cycles. Valid/ready handshakes are used on both the input and the
// output side.
//
// Parameters
//   WIDTH   binary input width in bits (>= 1)
//   DIGITS  number of BCD output digits (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_valid   in   in_data is valid
//   in_ready   out  converter can accept a value (IDLE only)
//   in_data    in   unsigned binary value, WIDTH bits
//   out_valid  out  out_bcd/out_ovf are valid (DONE only)
//   out_ready  in   consumer takes the result
//   out_bcd    out  packed BCD, digit 0 in bits [3:0]
//   out_ovf    out  the value did not fit in DIGITS digits
//
// Configuration macro
//   BCD_SERIAL_BLANK_EN  when defined, leading zero digits above digit 0 are
//                        shown as 4'hF while in DONE (blank code for the
//                        display decoder). The internal digits are unchanged.

module bcd_serial #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    // Every digit >= 5 gets +3, all from the current digit values. After the
    // correction a digit is at most 12, so it still fits in 4 bits.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj = add3_digits(bcd_q);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_q <= in_data;
                        bcd_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= CNT_W'(WIDTH);
                    end
                end
                BUSY: begin
                    // {bcd, shift} shifts left by one; the binary MSB enters
                    // digit 0 and the bit falling out of the top digit is
                    // remembered as overflow.
                    shift_q <= shift_q << 1;
                    bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
                    ovf_q   <= ovf_q | bcd_adj[BCD_W-1];
                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign out_ovf = ovf_q;

`ifdef BCD_SERIAL_BLANK_EN
    // Blank leading zeros from the top digit down, stopping at the first
    // non-zero digit. Digit 0 is never blanked. Only the presented result in
    // DONE is affected.
    logic lead;

    always_comb begin
        out_bcd = bcd_q;
        lead    = (state == DONE);
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (bcd_q[4*i +: 4] == 4'd0)) begin
                out_bcd[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign out_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_bcd_serial.sv
module tb_bcd_serial;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_bcd;
    logic        out_ovf;

    // 8-bit, 2-digit instance sharing the main inputs (runs in lock-step)
    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  out_bcd2;
    logic        out_ovf2;

    // 16-bit, 5-digit instance with its own handshake
    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] in_data16 = 16'd0;
    logic        out_valid16;
    logic        out_ready16 = 1'b0;
    logic [19:0] out_bcd16;
    logic        out_ovf16;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bcd_serial #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_ovf(out_ovf)
    );

    bcd_serial #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_bcd(out_bcd2), .out_ovf(out_ovf2)
    );

    bcd_serial #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_data(in_data16), .out_valid(out_valid16), .out_ready(out_ready16),
        .out_bcd(out_bcd16), .out_ovf(out_ovf16)
    );

    // Reference: decimal digits by division, plus display blanking in DONE
    function automatic logic [11:0] bcd3(input int v);
        logic [11:0] r;
        int t;
        t = v;
        r = '0;
        for (int d = 0; d < 3; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef BCD_SERIAL_BLANK_EN
        for (int d = 2; d >= 1; d--) begin
            if (r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'hF;
            else break;
        end
`endif
        return r;
    endfunction

    // Called at a negedge. Waits for in_ready, hands over v, and returns the
    // number of edges after the acceptance edge until out_valid is seen.
    // Returns at the negedge where out_valid was first seen (or 40 on timeout).
    task automatic start_conv(input logic [7:0] v, output int lat);
        for (int k = 0; k < 40; k++) begin
            if (in_ready === 1'b1) break;
            @(negedge clk);
        end
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({in_ready, out_valid, out_ovf, out_bcd} !== {1'b1, 1'b0, 1'b0, 12'h000})
            $display("FAIL reset_state: got rdy=%b vld=%b ovf=%b bcd=%h want rdy=1 vld=0 ovf=0 bcd=000",
                     in_ready, out_valid, out_ovf, out_bcd);
        else n_pass++;
        n_chk++;
        if ({in_ready16, out_valid16, out_bcd16} !== {1'b1, 1'b0, 20'h00000})
            $display("FAIL reset_state16: got rdy=%b vld=%b bcd=%h want 1 0 00000",
                     in_ready16, out_valid16, out_bcd16);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int  lat;
        bit  rdy_low;
        in_data  = 8'd255;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rdy_low  = 1'b1;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) rdy_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (in_ready !== 1'b0) rdy_low = 1'b0;
        n_chk++;
        if (lat !== 8) $display("FAIL basic_latency: got %0d edges after accept, want 8", lat);
        else n_pass++;
        n_chk++;
        if (rdy_low !== 1'b1) $display("FAIL basic_in_ready_low: got in_ready high in BUSY/DONE, want low");
        else n_pass++;
        n_chk++;
        if (out_bcd !== 12'h255) $display("FAIL basic_bcd: got %h want 255", out_bcd);
        else n_pass++;
        n_chk++;
        if (out_ovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", out_ovf);
        else n_pass++;
        release_out();
        n_chk++;
        if ({out_valid, in_ready, out_bcd} !== {1'b0, 1'b1, 12'h255})
            $display("FAIL basic_after_release: got vld=%b rdy=%b bcd=%h want vld=0 rdy=1 bcd=255",
                     out_valid, in_ready, out_bcd);
        else n_pass++;
    endtask

    task automatic test_sweep();
        int lat;
        out_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            start_conv(8'(v), lat);
            n_chk++;
            if ({out_valid, out_ovf, out_bcd} !== {1'b1, 1'b0, bcd3(v)})
                $display("FAIL sweep_%0d: got vld=%b ovf=%b bcd=%h want vld=1 ovf=0 bcd=%h",
                         v, out_valid, out_ovf, out_bcd, bcd3(v));
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        bit stable;
        start_conv(8'd42, lat);
        n_chk++;
        if (out_bcd !== bcd3(42)) $display("FAIL bp_bcd: got %h want %h", out_bcd, bcd3(42));
        else n_pass++;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data  = 8'd99;
            in_valid = 1'b1;
            @(negedge clk);
            if ({out_valid, in_ready, out_ovf, out_bcd} !== {1'b1, 1'b0, 1'b0, bcd3(42)})
                stable = 1'b0;
        end
        n_chk++;
        if (stable !== 1'b1) $display("FAIL bp_hold: got result changed under backpressure, want held %h", bcd3(42));
        else n_pass++;
        in_valid = 1'b0;
        release_out();
        n_chk++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        else n_pass++;
        n_chk++;
        if (out_bcd !== 12'h042) $display("FAIL bp_idle_bcd: got %h want 042", out_bcd);
        else n_pass++;
    endtask

    task automatic test_reset_busy();
        int lat;
        in_data  = 8'd200;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({in_ready, out_valid, out_ovf, out_bcd} !== {1'b1, 1'b0, 1'b0, 12'h000})
            $display("FAIL rst_busy_state: got rdy=%b vld=%b ovf=%b bcd=%h want 1 0 0 000",
                     in_ready, out_valid, out_ovf, out_bcd);
        else n_pass++;
        n_chk++;
        if ({in_ready2, out_bcd2} !== {1'b1, 8'h00})
            $display("FAIL rst_busy_state2: got rdy=%b bcd=%h want 1 00", in_ready2, out_bcd2);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_conv(8'd7, lat);
        n_chk++;
        if (lat !== 8) $display("FAIL rst_busy_latency: got %0d want 8", lat);
        else n_pass++;
        n_chk++;
        if ({out_ovf, out_bcd} !== {1'b0, bcd3(7)})
            $display("FAIL rst_busy_next: got ovf=%b bcd=%h want ovf=0 bcd=%h", out_ovf, out_bcd, bcd3(7));
        else n_pass++;
        release_out();
    endtask

    task automatic test_overflow();
        int lat;
        start_conv(8'd255, lat);
        n_chk++;
        if ({out_valid2, out_ovf2, out_bcd2} !== {1'b1, 1'b1, 8'h55})
            $display("FAIL ovf_255: got vld=%b ovf=%b bcd=%h want vld=1 ovf=1 bcd=55",
                     out_valid2, out_ovf2, out_bcd2);
        else n_pass++;
        release_out();
        start_conv(8'd99, lat);
        n_chk++;
        if ({out_ovf2, out_bcd2} !== {1'b0, 8'h99})
            $display("FAIL ovf_99: got ovf=%b bcd=%h want ovf=0 bcd=99", out_ovf2, out_bcd2);
        else n_pass++;
        release_out();
        start_conv(8'd100, lat);
        n_chk++;
`ifdef BCD_SERIAL_BLANK_EN
        if ({out_ovf2, out_bcd2} !== {1'b1, 8'hF0})
            $display("FAIL ovf_100: got ovf=%b bcd=%h want ovf=1 bcd=f0", out_ovf2, out_bcd2);
`else
        if ({out_ovf2, out_bcd2} !== {1'b1, 8'h00})
            $display("FAIL ovf_100: got ovf=%b bcd=%h want ovf=1 bcd=00", out_ovf2, out_bcd2);
`endif
        else n_pass++;
        release_out();
    endtask

    task automatic test_wide();
        int lat;
        n_chk++;
        if (in_ready16 !== 1'b1) $display("FAIL wide_ready: got %b want 1", in_ready16);
        else n_pass++;
        in_data16  = 16'd65535;
        in_valid16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        n_chk++;
        if (lat !== 16) $display("FAIL wide_latency: got %0d want 16", lat);
        else n_pass++;
        n_chk++;
        if ({out_ovf16, out_bcd16} !== {1'b0, 20'h65535})
            $display("FAIL wide_bcd: got ovf=%b bcd=%h want ovf=0 bcd=65535", out_ovf16, out_bcd16);
        else n_pass++;
        out_ready16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready16 = 1'b0;
    endtask

    task automatic test_blank();
        int lat;
        start_conv(8'd7, lat);
        n_chk++;
`ifdef BCD_SERIAL_BLANK_EN
        if (out_bcd !== 12'hFF7) $display("FAIL blank_7: got %h want ff7", out_bcd);
`else
        if (out_bcd !== 12'h007) $display("FAIL blank_7: got %h want 007", out_bcd);
`endif
        else n_pass++;
        release_out();
        n_chk++;
        if (out_bcd !== 12'h007) $display("FAIL blank_7_idle: got %h want 007", out_bcd);
        else n_pass++;
        start_conv(8'd0, lat);
        n_chk++;
`ifdef BCD_SERIAL_BLANK_EN
        if (out_bcd !== 12'hFF0) $display("FAIL blank_0: got %h want ff0", out_bcd);
`else
        if (out_bcd !== 12'h000) $display("FAIL blank_0: got %h want 000", out_bcd);
`endif
        else n_pass++;
        release_out();
        start_conv(8'd105, lat);
        n_chk++;
        if ({out_ovf, out_bcd} !== {1'b0, 12'h105})
            $display("FAIL blank_105: got ovf=%b bcd=%h want ovf=0 bcd=105", out_ovf, out_bcd);
        else n_pass++;
        release_out();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_backpressure();
        test_reset_busy();
        test_overflow();
        test_wide();
        test_blank();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
